// File: rtl/phy_tx_pkg.sv
// ----------------------------------------------------------------------------
// phy_tx_pkg: shared constants and state type for the striped serial TX path.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package phy_tx_pkg;

  localparam logic [7:0] COM = 8'hBC;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/phy_tx_fifo.sv
// ----------------------------------------------------------------------------
// phy_tx_fifo: word FIFO with wrap-bit pointers and show-ahead read data.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module phy_tx_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("phy_tx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q;
  logic [AW:0]       rptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_i)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/phy_tx_striped.sv
// ----------------------------------------------------------------------------
// phy_tx_striped: buffers parallel words and serialises them byte-striped
// across LANES outputs, filling idle word periods with COM. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module phy_tx_striped
  import phy_tx_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LANES      = 2,
  parameter int DEPTH      = 4,
  parameter int INIT_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in_flops,
  input  logic              validIn,
  output logic              ready,
  output logic [LANES-1:0]  out_tx_serial,
  output logic              word_strobe,
  output logic              tx_active,
  output logic              overflow
);

  localparam int BPL   = DATA_W / LANES;
  localparam int SLOTS = BPL / 8;
  localparam int CW    = $clog2(BPL);
  localparam int IW    = $clog2(INIT_WORDS + 2);

  if (LANES < 1 || DATA_W < 8 * LANES || (DATA_W % (8 * LANES)) != 0) begin : g_bad_width
    $error("phy_tx_striped: DATA_W must be a non-zero multiple of 8*LANES");
  end

  logic [CW-1:0]     cnt_q;
  logic              strobe_q;
  logic              live_q;
  logic              tx_active_q;
  logic              overflow_q;
  state_e            state_q;
  logic [IW-1:0]     init_cnt_q;

  logic              load;
  logic              push;
  logic              take;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [DATA_W-1:0] word_next;

  assign load  = strobe_q;
  assign ready = live_q && !fifo_full;
  assign push  = validIn && ready;

  // A word arriving on a load edge into an empty FIFO goes straight to the lanes.
  assign take      = load && (state_q == ST_RUN) && (!fifo_empty || push);
  assign bypass    = take && fifo_empty;
  assign fifo_push = push && !bypass;
  assign fifo_pop  = take && !fifo_empty;
  assign word_next = fifo_empty ? data_in_flops : fifo_rdata;

  phy_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (data_in_flops),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      strobe_q    <= 1'b0;
      live_q      <= 1'b0;
      tx_active_q <= 1'b0;
      overflow_q  <= 1'b0;
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
    end else begin
      live_q   <= 1'b1;
      cnt_q    <= load ? '0 : cnt_q + CW'(1);
      strobe_q <= (cnt_q == CW'(BPL - 2));
      if (validIn && !ready) overflow_q <= 1'b1;
      if (load) begin
        tx_active_q <= take;
        // INIT ends once INIT_WORDS COM periods have been loaded.
        case (state_q)
          ST_INIT: begin
            if (int'(init_cnt_q) + 1 >= INIT_WORDS) state_q <= ST_RUN;
            else                                    init_cnt_q <= init_cnt_q + IW'(1);
          end
          ST_RUN:  state_q <= ST_RUN;
          default: state_q <= ST_INIT;
        endcase
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BPL-1:0] lane_word;
    logic [BPL-1:0] sreg_d;
    logic [BPL-1:0] sreg_q;

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
      assign lane_word[BPL-1-8*s -: 8] = word_next[8*(s*LANES+l) +: 8];
    end

    always_comb begin
      sreg_d = sreg_q << 1;
      if (load) sreg_d = take ? lane_word : {SLOTS{COM}};
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sreg_q <= '0;
      else        sreg_q <= sreg_d;
    end

    assign out_tx_serial[l] = sreg_q[BPL-1];
  end

  assign word_strobe = strobe_q;
  assign tx_active   = tx_active_q;
  assign overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_phy_tx_striped.sv
// ----------------------------------------------------------------------------
// tb_phy_tx_striped: directed and random stimulus against a word-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_phy_tx_striped;

  localparam int DATA_W     = 32;
  localparam int LANES      = 2;
  localparam int DEPTH      = 4;
  localparam int INIT_WORDS = 4;
  localparam int BPL        = DATA_W / LANES;
  localparam logic [31:0] COM_WORD = 32'hBCBC_BCBC;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] data_in_flops;
  logic              validIn;
  logic              ready;
  logic [LANES-1:0]  out_tx_serial;
  logic              word_strobe;
  logic              tx_active;
  logic              overflow;

  int n_vec = 0;
  int n_err = 0;

  // Word-level reference state
  logic [31:0] m_q[$];
  logic [31:0] m_word;
  int          m_cnt, m_pos, m_init;
  bit          m_run, m_ready, m_ovf, m_loaded, m_active;

  phy_tx_striped #(
    .DATA_W     (DATA_W),
    .LANES      (LANES),
    .DEPTH      (DEPTH),
    .INIT_WORDS (INIT_WORDS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in_flops (data_in_flops),
    .validIn       (validIn),
    .ready         (ready),
    .out_tx_serial (out_tx_serial),
    .word_strobe   (word_strobe),
    .tx_active     (tx_active),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [31:0] w, input int lane, input int pos);
    int k;
    k = (pos / 8) * LANES + lane;
    return w[8*k + 7 - (pos % 8)];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_word = '0;
    m_cnt = 0; m_pos = 0; m_init = 0;
    m_run = 0; m_ready = 0; m_ovf = 0; m_loaded = 0; m_active = 0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d);
    if (v && !m_ready) m_ovf = 1;
    if (v && m_ready) m_q.push_back(d);
    if (m_cnt == BPL - 1) begin
      if (m_run && m_q.size() > 0) begin
        m_word = m_q.pop_front();
        m_active = 1;
      end else begin
        m_word = COM_WORD;
        m_active = 0;
      end
      if (!m_run) begin
        m_init++;
        if (m_init >= INIT_WORDS) m_run = 1;
      end
      m_loaded = 1;
      m_pos = 0;
      m_cnt = 0;
    end else begin
      m_cnt++;
      m_pos++;
    end
    m_ready = (m_q.size() < DEPTH);
  endtask

  task automatic check_outputs();
    logic [LANES-1:0] exp_out;
    for (int l = 0; l < LANES; l++)
      exp_out[l] = m_loaded ? exp_bit(m_word, l, m_pos) : 1'b0;
    chk("serial", 32'(out_tx_serial), 32'(exp_out));
    chk("word_strobe", 32'(word_strobe), 32'(m_cnt == BPL - 1));
    chk("tx_active", 32'(tx_active), 32'(m_active));
    chk("ready", 32'(ready), 32'(m_ready));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cycle(input bit v, input logic [31:0] d);
    validIn = v;
    data_in_flops = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    validIn = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  task automatic wait_cnt(input int target);
    for (int i = 0; i <= BPL && m_cnt != target; i++) cycle(1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] lane0_bits, lane1_bits;
    int n, act_cnt;

    reset = 1'b0;
    validIn = 1'b0;
    data_in_flops = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle link: COM on every lane through INIT and beyond
    idle(100);

    // Push on the load cycle into an empty FIFO: leaves on that very edge
    wait_cnt(BPL - 1);
    cycle(1'b1, 32'hA1B2_C3D4);
    chk("active_first", 32'(tx_active), 32'd1);
    lane0_bits = '0;
    lane1_bits = '0;
    for (int i = 0; i < BPL; i++) begin
      if (i > 0) cycle(1'b0, '0);
      lane0_bits = {lane0_bits[14:0], out_tx_serial[0]};
      lane1_bits = {lane1_bits[14:0], out_tx_serial[1]};
    end
    chk("lane0_word", 32'(lane0_bits), 32'h0000_D4B2);
    chk("lane1_word", 32'(lane1_bits), 32'h0000_C3A1);

    // Push at cnt==0: must wait for the next load edge
    wait_cnt(0);
    cycle(1'b1, 32'h1234_5678);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b0, '0);
      if (tx_active === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("latency_cnt0", 32'(n), 32'd15);
    idle(40);

    // Reset mid-word with three words still queued
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom);
    for (int i = 0; i < 3 * BPL && tx_active !== 1'b1; i++) cycle(1'b0, '0);
    chk("wait_active", 32'(tx_active), 32'd1);
    chk("queued_three", 32'(m_q.size()), 32'd3);
    idle(5);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_serial", 32'(out_tx_serial), 32'd0);
    chk("rst_active", 32'(tx_active), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    model_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    act_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      cycle(1'b0, '0);
      act_cnt += int'(tx_active);
    end
    chk("no_stale_data", 32'(act_cnt), 32'd0);

    // Overflow: five pushes during INIT, nothing can drain
    @(negedge clk);
    do_reset();
    idle(1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'hC0DE_0000 + 32'(i));
      if (i == 3) chk("ready_after4", 32'(ready), 32'd0);
    end
    chk("overflow_set", 32'(overflow), 32'd1);
    idle(150);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) cycle(($urandom % 3) == 0, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/phy_tx_striped.md
PHY_TX_STRIPED -- requirements
Module: phy_tx_striped

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning width of parallel input word.
REQ-002 The block SHALL have parameter LANES, default 2, meaning number of serial output lanes.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning input FIFO depth in words (power of 2, >=2).
REQ-004 The block SHALL have parameter INIT_WORDS, default 4, meaning word periods of COM sent after reset.
REQ-005 The block SHALL have port clk, input, 1, meaning single bit-rate clock; all logic on rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port data_in_flops, input, DATA_W, meaning parallel word to transmit.
REQ-008 The block SHALL have port validIn, input, 1, meaning data_in_flops valid this cycle.
REQ-009 The block SHALL have port ready, output, 1, meaning FIFO can accept a word this cycle.
REQ-010 The block SHALL have port out_tx_serial, output, LANES, meaning one serial bit per lane.
REQ-011 The block SHALL have port word_strobe, output, 1, meaning high on the cycle a new word period is loaded.
REQ-012 The block SHALL have port tx_active, output, 1, meaning current word period carries data, not COM.
REQ-013 The block SHALL have port overflow, output, 1, meaning sticky: a valid word was dropped.

Function
REQ-014 DATA_W SHALL be a multiple of 8*LANES; BPL = DATA_W/LANES bits per lane per word; violation SHALL fail elaboration.
REQ-015 Push: validIn && ready writes data_in_flops into FIFO tail; ready = !full.
REQ-016 validIn with ready low SHALL drop the word and set overflow, even if a pop occurs in the same cycle.
REQ-017 Free-running bit counter cnt counts 0..BPL-1 and wraps; load occurs when cnt == BPL-1.
REQ-018 At load: FIFO non-empty and state RUN -> pop head into lane shift registers, tx_active=1; else load COM (8'hBC) in every byte slot, tx_active=0.
REQ-019 Striping: byte k of word (bits 8k+7:8k) SHALL go to lane k mod LANES, slot k div LANES; slot 0 transmitted first, each byte MSB first.
REQ-020 out_tx_serial[l] SHALL be the MSB of lane l's shift register; register shifts left by 1 each non-load cycle.
REQ-021 First bit of a loaded word SHALL appear on out_tx_serial the cycle after the load edge.
REQ-022 A word pushed while FIFO empty SHALL be popped at the next load edge (minimum latency 1 cycle, maximum BPL cycles, to first bit).
REQ-023 Push and pop in the same cycle SHALL both occur; occupancy unchanged.
REQ-024 State machine: INIT -> RUN after INIT_WORDS completed word periods; in INIT only COM is sent and FIFO is not popped; ready follows !full in both states.
REQ-025 word_strobe SHALL be a one-cycle pulse coincident with each load edge; tx_active SHALL update at load and hold for the period.
REQ-026 FIFO pointers SHALL be log2(DEPTH)+1 bits; full/empty from wrap-bit comparison.

Reset
REQ-027 While reset low: out_tx_serial=0, ready=0, word_strobe=0, tx_active=0, overflow=0, cnt=0, FIFO empty, state INIT.
REQ-028 Reset asserted mid-word SHALL immediately discard FIFO contents and the in-flight word; after release first load occurs BPL-1 cycles later with COM.
REQ-029 ready SHALL go high the first clock edge after reset release.

Structure
REQ-030 Package phy_tx_pkg SHALL hold COM constant 8'hBC and the state enum (INIT, RUN).
REQ-031 The FIFO SHALL be sub-module phy_tx_fifo (parameters DATA_W, DEPTH; push/pop/full/empty).

Verification (defaults DATA_W=32, LANES=2, BPL=16)
REQ-032 Reset release, no validIn -> each lane repeats 1011_1100; tx_active=0; word_strobe every 16 cycles.
REQ-033 After INIT, push 32'hA1B2C3D4 -> lane0 sends D4 then B2, lane1 sends C3 then A1, MSB first; tx_active=1 for that period.
REQ-034 Push 5 words back-to-back with no pop possible -> ready low after 4th, 5th dropped, overflow=1 and stays 1.
REQ-035 Push on cycle cnt==15 with FIFO empty -> word popped same edge, first bit next cycle; push at cnt==0 -> waits 15 cycles.
REQ-036 Assert reset mid-data-word with 3 words queued -> outputs 0 at once; after release only COM until INIT completes, queued words never sent.
